// File: rtl/cpu65c02_pkg.sv
// -----------------------------------------------------------------------------
// cpu65c02_pkg
// Shared encodings for the 65C02 datapath blocks.
//   - PCH_CNTL operation codes (PCH_HOLD, PCH_LOAD, PCH_INC; 2'b11 also holds)
//   - ABH page-fixup FSM state encodings (ABH_IDLE, ABH_FIX)
//   - RESET_ABH_DEFAULT: ABH value after reset, pointing at the vector page
// -----------------------------------------------------------------------------
package cpu65c02_pkg;

    localparam logic [1:0] PCH_HOLD = 2'b00;
    localparam logic [1:0] PCH_LOAD = 2'b01;
    localparam logic [1:0] PCH_INC  = 2'b10;

    typedef enum logic {
        ABH_IDLE = 1'b0,
        ABH_FIX  = 1'b1
    } abh_state_e;

    localparam logic [7:0] RESET_ABH_DEFAULT = 8'hFF;

endpackage

// File: rtl/address_bus_high_register_if.sv
// -----------------------------------------------------------------------------
// address_bus_high_register_if
// Bundle between the instruction sequencer / ADH source mux (master) and the
// address-bus-high register (slave).
//   ADH_IN    : internal address bus high byte
//   ABH_LOAD  : capture ADH_IN into ABH
//   IDX_CARRY : index-add low-byte carry, qualified by ABH_LOAD
//   PCH_CNTL  : PCH operation (hold / load / increment-on-carry)
//   PCL_CARRY : carry out of the PCL incrementer
//   RDY       : 1 = advance, 0 = freeze all state
//   ABH_OUT   : registered external address high byte
//   PCH_OUT   : registered program counter high byte
//   PAGE_FIX  : high during the page-cross fixup cycle
// -----------------------------------------------------------------------------
interface address_bus_high_register_if #(
    parameter int WIDTH = 8
);
    logic             RDY;
    logic [WIDTH-1:0] ADH_IN;
    logic             ABH_LOAD;
    logic             IDX_CARRY;
    logic [1:0]       PCH_CNTL;
    logic             PCL_CARRY;
    logic [WIDTH-1:0] ABH_OUT;
    logic [WIDTH-1:0] PCH_OUT;
    logic             PAGE_FIX;

    modport master (
        output RDY, ADH_IN, ABH_LOAD, IDX_CARRY, PCH_CNTL, PCL_CARRY,
        input  ABH_OUT, PCH_OUT, PAGE_FIX
    );

    modport slave (
        input  RDY, ADH_IN, ABH_LOAD, IDX_CARRY, PCH_CNTL, PCL_CARRY,
        output ABH_OUT, PCH_OUT, PAGE_FIX
    );
endinterface

// File: rtl/address_bus_high_register_byte_incrementer.sv
// -----------------------------------------------------------------------------
// byte_incrementer
// Combinational WIDTH-bit +1 with wraparound; carry-out is discarded.
//   a_i : operand
//   y_o : a_i + 1 modulo 2^WIDTH
// -----------------------------------------------------------------------------
module byte_incrementer #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] y_o
);
    assign y_o = a_i + WIDTH'(1);
endmodule

// File: rtl/address_bus_high_register.sv
// -----------------------------------------------------------------------------
// address_bus_high_register
// Registered consumer of the ADH lines: latches the selected ADH byte into the
// external address-high output (ABH), holds PCH (load from ADH or increment on
// PCL carry) and inserts the one-cycle page-cross fixup for indexed modes.
//
// Ports:
//   CLK : core clock, rising edge
//   RST : asynchronous, active-high reset
//   bus : address_bus_high_register_if.slave (see interface file for signals)
//
// Configuration macro ABH_PAGE_FIX_EN:
//   defined   - IDLE/FIX FSM and ABH fixup increment are present
//   undefined - IDX_CARRY ignored, no FSM, PAGE_FIX tied to 0
// -----------------------------------------------------------------------------
module address_bus_high_register
    import cpu65c02_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_ABH = WIDTH'(RESET_ABH_DEFAULT)
) (
    input logic                       CLK,
    input logic                       RST,
    address_bus_high_register_if.slave bus
);

    logic [WIDTH-1:0] abh_q, abh_d;
    logic [WIDTH-1:0] pch_q, pch_d;
    logic [WIDTH-1:0] pch_inc;

    byte_incrementer #(.WIDTH(WIDTH)) u_pch_inc (
        .a_i (pch_q),
        .y_o (pch_inc)
    );

    // PCH path runs independently of the fixup FSM.
    always_comb begin
        pch_d = pch_q;
        if (bus.RDY) begin
            case (bus.PCH_CNTL)
                PCH_LOAD: pch_d = bus.ADH_IN;
                PCH_INC:  if (bus.PCL_CARRY) pch_d = pch_inc;
                default:  pch_d = pch_q;
            endcase
        end
    end

`ifdef ABH_PAGE_FIX_EN
    abh_state_e       state_q, state_d;
    logic [WIDTH-1:0] abh_inc;

    byte_incrementer #(.WIDTH(WIDTH)) u_abh_inc (
        .a_i (abh_q),
        .y_o (abh_inc)
    );

    // In FIX the fixup wins over any ABH_LOAD the sequencer may present.
    always_comb begin
        state_d = state_q;
        abh_d   = abh_q;
        if (bus.RDY) begin
            case (state_q)
                ABH_IDLE: begin
                    if (bus.ABH_LOAD) begin
                        abh_d = bus.ADH_IN;
                        if (bus.IDX_CARRY) state_d = ABH_FIX;
                    end
                end
                ABH_FIX: begin
                    abh_d   = abh_inc;
                    state_d = ABH_IDLE;
                end
                default: state_d = ABH_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ABH_IDLE;
        else     state_q <= state_d;
    end

    // The one-bit state register is itself the PAGE_FIX flop.
    assign bus.PAGE_FIX = (state_q == ABH_FIX);
`else
    logic unused_idx_carry;
    assign unused_idx_carry = bus.IDX_CARRY;

    always_comb begin
        abh_d = abh_q;
        if (bus.RDY && bus.ABH_LOAD) abh_d = bus.ADH_IN;
    end

    assign bus.PAGE_FIX = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            abh_q <= RESET_ABH;
            pch_q <= '0;
        end else begin
            abh_q <= abh_d;
            pch_q <= pch_d;
        end
    end

    assign bus.ABH_OUT = abh_q;
    assign bus.PCH_OUT = pch_q;

endmodule

// File: doc/address_bus_high_register.md
# address_bus_high_register

Registered consumer of the internal address-bus-high (ADH) lines in the 65C02 datapath. It latches the selected ADH byte into the external address-high output (ABH) and holds the program-counter high byte (PCH), which loads from ADH or increments on low-byte carry. It also inserts the one-cycle page-cross fixup for indexed addressing. It sits between the ADH source mux and the external A[15:8] pins, under control of the instruction sequencer.

## Interface
Parameters:
- WIDTH, 8, byte width of ADH/ABH/PCH
- RESET_ABH, 8'hFF, ABH value after reset, pointing at the vector page

Ports:
- CLK  input  1  core clock; all state updates on the rising edge
- RST  input  1  asynchronous, active-high reset
- RDY  input  1  1 = advance; 0 = freeze all state, including the FSM
- ADH_IN  input  WIDTH  internal address bus high, from the ADH source mux
- ABH_LOAD  input  1  capture ADH_IN into ABH
- IDX_CARRY  input  1  carry out of the index add on the low byte; qualified by ABH_LOAD
- PCH_CNTL  input  2  PCH operation: 00 hold, 01 load ADH_IN, 10 increment if PCL_CARRY, 11 hold
- PCL_CARRY  input  1  carry out of the PCL incrementer
- ABH_OUT  output  WIDTH  external address high byte, registered
- PCH_OUT  output  WIDTH  program counter high byte, registered
- PAGE_FIX  output  1  high during the fixup cycle; the sequencer stalls its step while it is high

## Operation
- Reset values: ABH_OUT = RESET_ABH, PCH_OUT = 0, PAGE_FIX = 0, FSM = IDLE.
- RDY = 0: no register or FSM state changes. All outputs hold their values, and PAGE_FIX stays asserted if it was asserted.
- ABH path in IDLE:
  - ABH_LOAD = 1: ABH_OUT <= ADH_IN.
  - ABH_LOAD = 1 with IDX_CARRY = 1: the load happens and the FSM moves to FIX.
  - ABH_LOAD = 0: ABH_OUT holds, and IDX_CARRY is ignored.
- FSM states: IDLE and FIX.
  - IDLE -> FIX on ABH_LOAD & IDX_CARRY & RDY.
  - FIX -> IDLE on RDY. On that same edge, ABH_OUT <= ABH_OUT + 1, modulo 2^WIDTH, so FF wraps to 00.
  - PAGE_FIX is 1 exactly while the FSM is in FIX.
  - ABH_LOAD during FIX is ignored; the fixup has priority. A sequencer that asserts ABH_LOAD during FIX is a protocol error.
- PCH path is independent of the FSM:
  - 01: PCH_OUT <= ADH_IN.
  - 10 with PCL_CARRY: PCH_OUT <= PCH_OUT + 1, wrapping FF to 00.
  - 10 without PCL_CARRY, 00, and 11: hold.
- Arithmetic: all increments are WIDTH-bit; carry-out is discarded.
- Reset during FIX: the FSM returns to IDLE immediately and no pending increment is applied.

## Timing
- Every output is a flop, and there is no combinational path from inputs to outputs.
- ABH_OUT and PCH_OUT reflect a load or increment one cycle after the qualifying edge.
- PAGE_FIX rises one cycle after the load-with-carry. It lasts one cycle per RDY-high cycle: exactly one cycle with RDY held high, longer if RDY drops.
- The corrected ABH appears on the edge where PAGE_FIX falls.

## Configuration
- ABH_PAGE_FIX_EN
  - Defined: the FIX state and the ABH increment are present, and behaviour is as above.
  - Undefined:
    - IDX_CARRY is ignored.
    - The FSM is removed and the block stays permanently in IDLE behaviour.
    - PAGE_FIX is tied to 0.
    - The sequencer then performs the high-byte fixup through the ALU and the ADH mux instead.

## Structure
- Shared package cpu65c02_pkg holds:
  - the PCH_CNTL encodings (PCH_HOLD, PCH_LOAD, PCH_INC)
  - the FSM state encodings (ABH_IDLE, ABH_FIX)
  - the RESET_ABH default constant
- One sub-module, byte_incrementer (WIDTH-bit, combinational, +1 with wrap). It is instantiated twice: once for the PCH increment and once for the ABH fixup.

## Test plan
- Assert RST mid-run, then release -> ABH_OUT = FF, PCH_OUT = 00, PAGE_FIX = 0, asynchronously during reset and held after release.
- ABH_LOAD = 1, ADH_IN = 12, IDX_CARRY = 0 -> next cycle ABH_OUT = 12, PAGE_FIX stays 0.
- ABH_LOAD = 1, ADH_IN = 12, IDX_CARRY = 1 -> cycle+1 ABH_OUT = 12 with PAGE_FIX = 1; cycle+2 ABH_OUT = 13 with PAGE_FIX = 0. Repeat with ADH_IN = FF -> ABH_OUT wraps to 00.
- Same load-with-carry, then RDY = 0 for 3 cycles while in FIX -> PAGE_FIX held 1 and ABH_OUT held 12; increment to 13 on the first edge with RDY = 1.
- PCH_CNTL = 01, ADH_IN = FF, then PCH_CNTL = 10 with PCL_CARRY = 1 -> PCH_OUT = FF, then 00. PCH_CNTL = 10 with PCL_CARRY = 0, or PCH_CNTL = 11 -> PCH_OUT unchanged.
- Build without ABH_PAGE_FIX_EN, load ADH_IN = 12 with IDX_CARRY = 1 -> ABH_OUT = 12 indefinitely, PAGE_FIX constant 0.
